// File: rtl/preset_keypad_entry.sv
// Four-key BCD setpoint entry (0000-9999) with per-digit editing, cursor blink,
// auto-repeat on UP/DOWN and a registered binary preset with change strobe.
module preset_keypad_entry #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned BLINK_HALF_MS   = 250,
  parameter int unsigned DEFAULT_VALUE   = 1234
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        edit_en,
  input  logic [3:0]  keys,
  output logic [13:0] preset,
  output logic [15:0] bcd,
  output logic [1:0]  cursor,
  output logic [3:0]  blank_mask,
  output logic        preset_stb
);

  localparam int unsigned DELAY_CYC = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int unsigned RATE_CYC  = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int unsigned BLINK_CYC = CLK_HZ / 1000 * BLINK_HALF_MS;
  localparam int unsigned MAX_AB    = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int unsigned MAX_CYC   = (MAX_AB > BLINK_CYC) ? MAX_AB : BLINK_CYC;
  localparam int unsigned CW        = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DELAY_C    = CW'(DELAY_CYC);
  localparam logic [CW-1:0] RATE_C     = CW'(RATE_CYC);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [3:0]  DEF_D0 = 4'(DEFAULT_VALUE % 10);
  localparam logic [3:0]  DEF_D1 = 4'((DEFAULT_VALUE / 10) % 10);
  localparam logic [3:0]  DEF_D2 = 4'((DEFAULT_VALUE / 100) % 10);
  localparam logic [3:0]  DEF_D3 = 4'((DEFAULT_VALUE / 1000) % 10);
  localparam logic [13:0] DEF_BIN = 14'(DEFAULT_VALUE);

  typedef enum logic [2:0] {IDLE, HOLD, REPEAT, WAIT_REL, LOCK} state_t;

  state_t             state_q, state_n;
  logic [CW-1:0]      rep_cnt_q, rep_cnt_n;
  logic [3:0]         keys_prev;
  logic               armed;
  logic               do_act;
  logic [3:0][3:0]    dig;
  logic [1:0]         cur_q;
  logic [13:0]        preset_q, preset_n;
  logic               stb_q;
  logic [CW-1:0]      blink_cnt;
  logic               phase;
  logic               edit_en_q;
  logic [13:0]        e3, e2, e1, e0;

  // Key history and the release-seen flag; a key held through reset must be
  // released once before any press is honoured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keys_prev <= '0;
      armed     <= 1'b0;
      edit_en_q <= 1'b0;
    end else begin
      keys_prev <= keys;
      edit_en_q <= edit_en;
      if (keys == '0) armed <= 1'b1;
    end
  end

  // FSM state and repeat counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      rep_cnt_q <= rep_cnt_n;
    end
  end

  // Next-state, repeat countdown and action qualification.
  always_comb begin
    state_n   = state_q;
    rep_cnt_n = rep_cnt_q;
    do_act    = 1'b0;
    if (!edit_en) begin
      state_n   = (keys != '0) ? LOCK : IDLE;
      rep_cnt_n = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (keys != '0) begin
            if ($onehot(keys) && ((keys & keys_prev) == '0) && armed) begin
              do_act = 1'b1;
              if (keys[0] || keys[1]) begin
                state_n   = HOLD;
                rep_cnt_n = DELAY_C;
              end else begin
                state_n = WAIT_REL;
              end
            end else begin
              state_n = LOCK;
            end
          end
        end
        HOLD, REPEAT: begin
          if (keys == '0) begin
            state_n   = IDLE;
            rep_cnt_n = '0;
          end else if (keys != keys_prev) begin
            state_n   = LOCK;
            rep_cnt_n = '0;
          end else if (rep_cnt_q <= CNT_ONE) begin
            do_act    = 1'b1;
            state_n   = REPEAT;
            rep_cnt_n = RATE_C;
          end else begin
            rep_cnt_n = rep_cnt_q - CNT_ONE;
          end
        end
        WAIT_REL: begin
          if (keys == '0)             state_n = IDLE;
          else if (keys != keys_prev) state_n = LOCK;
        end
        LOCK: begin
          if (keys == '0) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Digit and cursor update; the active key selects the action, no carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig   <= {DEF_D3, DEF_D2, DEF_D1, DEF_D0};
      cur_q <= '0;
    end else if (do_act) begin
      if (keys[0])
        dig[cur_q] <= (dig[cur_q] == 4'd9) ? 4'd0 : dig[cur_q] + 4'd1;
      else if (keys[1])
        dig[cur_q] <= (dig[cur_q] == 4'd0) ? 4'd9 : dig[cur_q] - 4'd1;
      else if (keys[2])
        cur_q <= cur_q + 2'd1;
      else if (keys[3])
        cur_q <= cur_q - 2'd1;
    end
  end

  // BCD to binary with constant shift-add: 1000=512+256+128+64+32+8, 100=64+32+4, 10=8+2.
  always_comb begin
    e3 = {10'd0, dig[3]};
    e2 = {10'd0, dig[2]};
    e1 = {10'd0, dig[1]};
    e0 = {10'd0, dig[0]};
    preset_n = (e3 << 9) + (e3 << 8) + (e3 << 7) + (e3 << 6) + (e3 << 5) + (e3 << 3)
             + (e2 << 6) + (e2 << 5) + (e2 << 2)
             + (e1 << 3) + (e1 << 1)
             + e0;
  end

  // Registered preset one cycle behind the digits, strobe when it changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset_q <= DEF_BIN;
      stb_q    <= 1'b0;
    end else begin
      preset_q <= preset_n;
      stb_q    <= (preset_n != preset_q);
    end
  end

  // Cursor blink phase; restarts on edit entry and on every action.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!edit_en || !edit_en_q || do_act) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_ONE;
    end
  end

  assign preset     = preset_q;
  assign bcd        = dig;
  assign cursor     = cur_q;
  assign preset_stb = stb_q;
  assign blank_mask = phase ? (4'b0001 << cur_q) : 4'b0000;

endmodule

// File: tb/tb_preset_keypad_entry.sv
// Directed bench for preset_keypad_entry with 1 ms = 1 cycle timing.
module tb_preset_keypad_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        edit_en;
  logic [3:0]  keys;
  logic [13:0] preset;
  logic [15:0] bcd;
  logic [1:0]  cursor;
  logic [3:0]  blank_mask;
  logic        preset_stb;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;

  localparam logic [3:0] K_UP = 4'b0001, K_DN = 4'b0010, K_LT = 4'b0100, K_RT = 4'b1000;

  preset_keypad_entry #(
    .CLK_HZ(1000),
    .REPEAT_DELAY_MS(500),
    .REPEAT_RATE_MS(100),
    .BLINK_HALF_MS(250),
    .DEFAULT_VALUE(1234)
  ) dut (
    .clk(clk),
    .reset(reset),
    .edit_en(edit_en),
    .keys(keys),
    .preset(preset),
    .bcd(bcd),
    .cursor(cursor),
    .blank_mask(blank_mask),
    .preset_stb(preset_stb)
  );

  always #5 clk = ~clk;

  // Count strobe pulses away from the active edge.
  always @(negedge clk) if (reset && preset_stb) stb_cnt++;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int unsigned bcd2bin(input logic [15:0] b);
    return 1000 * b[15:12] + 100 * b[11:8] + 10 * b[7:4] + b[3:0];
  endfunction

  // One-cycle press then release, checking edit latency and strobe timing.
  task automatic press(input logic [3:0] k, input logic [15:0] eb, input logic [1:0] ec, input logic es);
    keys = k;
    step(1);
    check("bcd", bcd, eb);
    check("cursor", cursor, ec);
    check("stb_early", preset_stb, 0);
    keys = '0;
    step(1);
    check("preset", preset, bcd2bin(eb));
    check("stb", preset_stb, es);
    step(1);
    check("stb_off", preset_stb, 0);
    step(1);
  endtask

  initial begin
    // Reset with UP held and editing enabled.
    reset = 1'b0; edit_en = 1'b1; keys = K_UP;
    repeat (3) @(posedge clk);
    #1;
    check("rst_preset", preset, 1234);
    check("rst_bcd", bcd, 16'h1234);
    check("rst_cursor", cursor, 0);
    check("rst_mask", blank_mask, 0);
    check("rst_stb", preset_stb, 0);
    reset = 1'b1;
    step(5);
    check("held_bcd", bcd, 16'h1234);
    check("held_preset", preset, 1234);
    check("held_stb_cnt", stb_cnt, 0);
    keys = '0;
    step(2);

    // Six UP presses on the units digit, no carry.
    press(K_UP, 16'h1235, 0, 1);
    press(K_UP, 16'h1236, 0, 1);
    press(K_UP, 16'h1237, 0, 1);
    press(K_UP, 16'h1238, 0, 1);
    press(K_UP, 16'h1239, 0, 1);
    press(K_UP, 16'h1230, 0, 1);
    check("stb_cnt_up", stb_cnt, 6);

    // Cursor moves and DOWN with wrap on the hundreds digit.
    press(K_LT, 16'h1230, 1, 0);
    press(K_LT, 16'h1230, 2, 0);
    press(K_DN, 16'h1130, 2, 1);
    press(K_DN, 16'h1030, 2, 1);
    press(K_DN, 16'h1930, 2, 1);
    press(K_RT, 16'h1930, 1, 0);
    press(K_RT, 16'h1930, 0, 0);
    press(K_RT, 16'h1930, 3, 0);
    press(K_LT, 16'h1930, 0, 0);
    check("stb_cnt_dn", stb_cnt, 9);

    // Auto-repeat: actions at hold cycles 0, 500, 600, 700.
    keys = K_UP;
    step(1);   check("rep_c0", bcd, 16'h1931);
    step(499); check("rep_c499", bcd, 16'h1931);
    step(1);   check("rep_c500", bcd, 16'h1932);
    step(99);  check("rep_c599", bcd, 16'h1932);
    step(1);   check("rep_c600", bcd, 16'h1933);
    step(100); check("rep_c700", bcd, 16'h1934);
    step(49);  check("rep_c749", bcd, 16'h1934);
    keys = '0;
    step(200);
    check("rep_rel_bcd", bcd, 16'h1934);
    check("rep_rel_preset", preset, 1934);
    check("stb_cnt_rep", stb_cnt, 13);

    // UP+DOWN together: locked out.
    keys = K_UP | K_DN; step(3);
    keys = '0;          step(3);
    check("dual_bcd", bcd, 16'h1934);
    check("dual_cursor", cursor, 0);
    check("stb_cnt_dual", stb_cnt, 13);

    // UP (acts once), add RIGHT, drop UP with RIGHT held: no further edits.
    keys = K_UP;        step(1);
    check("mix_up_bcd", bcd, 16'h1935);
    step(2);
    keys = K_UP | K_RT; step(3);
    keys = K_RT;        step(3);
    check("mix_bcd", bcd, 16'h1935);
    check("mix_cursor", cursor, 0);
    keys = '0;          step(3);
    check("stb_cnt_mix", stb_cnt, 14);
    press(K_UP, 16'h1936, 0, 1);

    // Move cursor to tens, then show edit_en=0 blocks UP and blanking.
    press(K_LT, 16'h1936, 1, 0);
    edit_en = 1'b0;
    step(3);
    check("dis_mask", blank_mask, 0);
    keys = K_UP; step(2);
    check("dis_bcd", bcd, 16'h1936);
    check("dis_mask_key", blank_mask, 0);
    keys = '0;   step(2);
    check("dis_stb_cnt", stb_cnt, 15);

    // Blink from edit_en rise with cursor at 1.
    edit_en = 1'b1;
    step(1);   check("blink_c0", blank_mask, 4'b0000);
    step(249); check("blink_c249", blank_mask, 4'b0000);
    step(1);   check("blink_c250", blank_mask, 4'b0010);
    step(249); check("blink_c499", blank_mask, 4'b0010);
    step(1);   check("blink_c500", blank_mask, 4'b0000);
    step(250); check("blink_c750", blank_mask, 4'b0010);
    keys = K_UP;
    step(1);
    check("blink_act_mask", blank_mask, 4'b0000);
    check("blink_act_bcd", bcd, 16'h1946);
    keys = '0;
    step(1);
    check("blink_act_stb", preset_stb, 1);
    check("blink_act_preset", preset, 1946);
    edit_en = 1'b0;
    step(1);
    check("final_mask", blank_mask, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
